// File: rtl/parking_lot_counter.sv
// Gate sensor decoder: synchronises the A/B photo-sensors, tracks entry/exit
// sequences with an FSM and keeps a saturating occupancy count.
module parking_lot_counter #(
    parameter int unsigned MAX_COUNT = 25,
    parameter int unsigned CW        = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          A,
    input  logic          B,
    output logic [CW-1:0] COUNT,
    output logic          ENTER,
    output logic          EXIT,
    output logic          FULL,
    output logic          EMPTY
);

    typedef enum logic [2:0] {
        StIdle, StE1, StE2, StE3, StX1, StX2, StX3, StWait
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    a_sync_q, b_sync_q;
    logic [1:0]    ab;
    logic          enter_q, enter_d;
    logic          exit_q, exit_d;
    logic [CW-1:0] count_q, count_d;

    localparam logic [CW-1:0] MaxCnt = CW'(MAX_COUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
            state_q  <= StIdle;
            enter_q  <= 1'b0;
            exit_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            a_sync_q <= {a_sync_q[0], A};
            b_sync_q <= {b_sync_q[0], B};
            state_q  <= state_d;
            enter_q  <= enter_d;
            exit_q   <= exit_d;
            count_q  <= count_d;
        end
    end

    assign ab = {a_sync_q[1], b_sync_q[1]};

    // Any pattern not listed for a state is a two-bit jump and parks in StWait.
    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                case (ab)
                    2'b00:   state_d = StIdle;
                    2'b10:   state_d = StE1;
                    2'b01:   state_d = StX1;
                    default: state_d = StWait;
                endcase
            end
            StE1: begin
                case (ab)
                    2'b10:   state_d = StE1;
                    2'b11:   state_d = StE2;
                    2'b00:   state_d = StIdle;
                    default: state_d = StWait;
                endcase
            end
            StE2: begin
                case (ab)
                    2'b11:   state_d = StE2;
                    2'b01:   state_d = StE3;
                    2'b10:   state_d = StE1;
                    default: state_d = StWait;
                endcase
            end
            StE3: begin
                case (ab)
                    2'b01:   state_d = StE3;
                    2'b00: begin
                        state_d = StIdle;
                        enter_d = 1'b1;
                    end
                    2'b11:   state_d = StE2;
                    default: state_d = StWait;
                endcase
            end
            StX1: begin
                case (ab)
                    2'b01:   state_d = StX1;
                    2'b11:   state_d = StX2;
                    2'b00:   state_d = StIdle;
                    default: state_d = StWait;
                endcase
            end
            StX2: begin
                case (ab)
                    2'b11:   state_d = StX2;
                    2'b10:   state_d = StX3;
                    2'b01:   state_d = StX1;
                    default: state_d = StWait;
                endcase
            end
            StX3: begin
                case (ab)
                    2'b10:   state_d = StX3;
                    2'b00: begin
                        state_d = StIdle;
                        exit_d  = 1'b1;
                    end
                    2'b11:   state_d = StX2;
                    default: state_d = StWait;
                endcase
            end
            StWait: begin
                if (ab == 2'b00) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Saturate at both ends; the pulse still fires when the count holds.
    always_comb begin
        count_d = count_q;
        if (enter_d && (count_q != MaxCnt)) begin
            count_d = count_q + 1'b1;
        end else if (exit_d && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    assign COUNT = count_q;
    assign ENTER = enter_q;
    assign EXIT  = exit_q;
    assign FULL  = (count_q == MaxCnt);
    assign EMPTY = (count_q == '0);

endmodule

// File: tb/tb_parking_lot_counter.sv
// Randomised scoreboard bench for parking_lot_counter: a path-position model
// predicts pulses and counts; a monitor pops predictions as the DUT pulses.
module tb_parking_lot_counter;

    localparam int MaxCount = 25;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_in = 1'b0;
    logic       b_in = 1'b0;
    logic [4:0] count;
    logic       enter, exit_o, full, empty;

    parking_lot_counter #(
        .MAX_COUNT(MaxCount),
        .CW       (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .A    (a_in),
        .B    (b_in),
        .COUNT(count),
        .ENTER(enter),
        .EXIT (exit_o),
        .FULL (full),
        .EMPTY(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_exit;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_count = 0;

    // Model: position along the entry or exit gray path, plus a recovery flag.
    bit   m_wait = 0;
    bit   m_dir = 0;
    int   m_pos = 0;
    int   m_count = 0;
    logic [1:0] cur_ab = 2'b00;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int path_idx(input bit dir, input logic [1:0] p);
        logic [1:0] seq [4];
        if (!dir) seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        else      seq = '{2'b00, 2'b01, 2'b11, 2'b10};
        for (int i = 0; i < 4; i++) if (seq[i] == p) return i;
        return 0;
    endfunction

    task automatic model_step(input logic [1:0] p);
        int j;
        if (m_wait) begin
            if (p == 2'b00) begin
                m_wait = 0;
                m_pos  = 0;
            end
            return;
        end
        if (m_pos == 0) begin
            case (p)
                2'b10: begin m_dir = 0; m_pos = 1; end
                2'b01: begin m_dir = 1; m_pos = 1; end
                2'b11: m_wait = 1;
                default: ;
            endcase
            return;
        end
        j = path_idx(m_dir, p);
        if (j == m_pos) return;
        if (j == (m_pos + 1) % 4) begin
            if (j == 0) begin
                if (!m_dir) m_count = (m_count < MaxCount) ? m_count + 1 : m_count;
                else        m_count = (m_count > 0) ? m_count - 1 : 0;
                exp_q.push_back('{is_exit: m_dir, cnt: m_count});
            end
            m_pos = j;
        end else if (j == (m_pos + 3) % 4) begin
            m_pos = j;
        end else begin
            m_wait = 1;
        end
    endtask

    // Called right after a negedge; returns on a later negedge.
    task automatic apply(input logic [1:0] p, input int hold);
        a_in   = p[1];
        b_in   = p[0];
        cur_ab = p;
        model_step(p);
        repeat (hold) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_in  = 1'b0;
        b_in  = 1'b0;
        cur_ab = 2'b00;
        m_wait = 0;
        m_pos = 0;
        m_count = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic car_in(input int hold);
        apply(2'b10, hold); apply(2'b11, hold); apply(2'b01, hold); apply(2'b00, hold);
    endtask

    task automatic car_out(input int hold);
        apply(2'b01, hold); apply(2'b11, hold); apply(2'b10, hold); apply(2'b00, hold);
    endtask

    // Monitor: samples just after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                exp_q.delete();
                exp_count = 0;
                check("reset_state", int'({count, enter, exit_o, full, empty}), int'({5'd0, 4'b0001}));
            end else begin
                check("pulse_mutex", int'(enter & exit_o), 0);
                if (enter | exit_o) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pulse: enter=%0b exit=%0b count=%0d at %0t",
                                 enter, exit_o, count, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_kind_exit", int'(exit_o), int'(e.is_exit));
                        check("pulse_count", int'(count), e.cnt);
                        exp_count = e.cnt;
                    end
                end
                check("count_flags", int'({count, full, empty}),
                      (exp_count << 2) | (int'(exp_count == MaxCount) << 1) | int'(exp_count == 0));
            end
        end
    end

    initial begin
        logic [1:0] nxt;
        @(negedge clk);
        do_reset();

        // T1 / T2: one entry then one exit
        car_in(3);
        car_out(3);
        // T3: back-out, then illegal jump through recovery
        apply(2'b10, 3); apply(2'b11, 3); apply(2'b10, 3); apply(2'b00, 3);
        apply(2'b11, 3); apply(2'b00, 3);
        // T5: exit at zero holds count
        car_out(2);
        // T4: fill past capacity
        for (int i = 0; i < 26; i++) car_in(1 + (i % 3));
        apply(2'b00, 4);
        check("full_after_26", int'({count, full}), (MaxCount << 1) | 1);
        // T6: reset while in E3 with count 7
        do_reset();
        for (int i = 0; i < 7; i++) car_in(2);
        apply(2'b10, 3); apply(2'b11, 3); apply(2'b01, 3);
        do_reset();
        repeat (6) @(negedge clk);
        check("after_mid_reset", int'({count, enter, empty}), 1);

        // Random walk: mostly single-bit steps, occasional arbitrary jumps.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 85) nxt = cur_ab ^ (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01);
            else nxt = 2'($urandom_range(0, 3));
            apply(nxt, $urandom_range(1, 4));
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        apply(2'b00, 4);
        // Drive a few more entries to exercise counts after the walk.
        for (int i = 0; i < 5; i++) car_in($urandom_range(1, 3));
        apply(2'b00, 8);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
